icb_reg_slave: RTL and testbench
================================

Name: icb_reg_slave

Overview:
Parametrised ICB register-bank slave. It is the next generation of the single-purpose icb_interface used by the robotic-arm peripheral.
- Generalised register counts and data width.
- Control (R/W) and status (RO) register regions.
- Error response on out-of-range access.
- One-entry response buffer with proper back-pressure.
- Sits between the e203 ICB peripheral fabric and the arm/PWM/encoder logic, which consume the control registers and supply the status words.

Parameters:
- DW, 32, data width of registers, wdata and rdata.
- AW, 12, ICB address width; byte addressing, word index = addr[AW-1:2].
- NUM_CTRL, 8, number of R/W control registers, word index 0..NUM_CTRL-1.
- NUM_STAT, 4, number of read-only status words, word index NUM_CTRL..NUM_CTRL+NUM_STAT-1.
- CTRL_RST, 0, reset value of every control register (DW bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_icb_cmd_valid  in  1  command valid.
- i_icb_cmd_ready  out  1  command ready.
- i_icb_cmd_addr  in  AW  byte address.
- i_icb_cmd_read  in  1  1 = read, 0 = write.
- i_icb_cmd_wdata  in  DW  write data.
- i_icb_cmd_wmask  in  DW/8  byte write mask; present only with ICB_SLV_WMASK_EN.
- i_icb_rsp_valid  out  1  response valid.
- i_icb_rsp_ready  in  1  response ready.
- i_icb_rsp_rdata  out  DW  read data (0 for writes and errors).
- i_icb_rsp_err  out  1  access error.
- ctrl_regs_o  out  NUM_CTRL*DW  flat control-register bus; register k occupies bits [k*DW +: DW].
- status_i  in  NUM_STAT*DW  flat status bus, same packing.
- wr_pulse_o  out  NUM_CTRL  one-cycle pulse on the cycle after register k is written.

Behaviour:
- Reset values (async on rst_n low):
  - i_icb_rsp_valid = 0, i_icb_rsp_rdata = 0, i_icb_rsp_err = 0.
  - All control registers = CTRL_RST.
  - wr_pulse_o = 0.
  - i_icb_cmd_ready = 1 once rst_n is high.
- Handshakes:
  - cmd fire = cmd_valid & cmd_ready.
  - rsp fire = rsp_valid & rsp_ready.
  - cmd_ready = ~rsp_valid | rsp_ready (combinational). A new command is accepted in the same cycle the pending response is consumed, giving full throughput of 1 transaction/cycle.
- Latency: response valid exactly 1 cycle after cmd fire.
- Response stability: rsp_valid, rdata and err hold stable until rsp fire.
- Response clearing: rsp_valid clears on rsp fire unless a new cmd fires in the same cycle, in which case it stays high with the new data.
- Decode: idx = addr[AW-1:2]; addr[1:0] are ignored.
  - idx < NUM_CTRL: control region.
  - NUM_CTRL <= idx < NUM_CTRL+NUM_STAT: status region.
  - Otherwise: error.
- Write to a control register:
  - Register updates on the cmd fire edge.
  - wr_pulse_o[idx] is high for the following cycle.
  - Response rdata = 0, err = 0.
- Write to the status region, or to an out-of-range index:
  - No state change, no pulse.
  - Response err = 1, rdata = 0.
- Read from the control region: rdata = register value before any write in that cycle. Reads and writes never coincide, since there is one command per cycle.
- Read from the status region: rdata = status word sampled at the cmd fire edge; err = 0.
- Read from an out-of-range index: rdata = 0, err = 1.
- Back-to-back sequences: write then read of the same register in consecutive cycles returns the new value.
- rsp_ready low: cmd_ready drops while rsp_valid = 1. No command is lost or duplicated; a cmd_valid held with stable fields is accepted once ready returns.
- Reset mid-transaction: a pending response is discarded, registers return to CTRL_RST, and no pulse is produced.
- Register implementation: control registers are flops; there is no RAM inference. NUM_CTRL + NUM_STAT must be <= 2^(AW-2); this is checked by an elaboration-time assertion.

Optional Feature:
- Macro: ICB_SLV_WMASK_EN.
- Defined: i_icb_cmd_wmask exists. On a control write, byte b of the register is written only when wmask[b] = 1. wr_pulse_o fires whenever any mask bit is set. A write with wmask = 0 gives err = 0, no change and no pulse.
- Undefined: the port is absent and every write updates all DW bits.

Test Plan:
- Reset, rsp_ready tied high; write 0x0000000A, 0x0000000C, 0x0000000E to addr 0x0, 0x4, 0x8 back-to-back, then read addr 0x0, 0xC, 0x8.
  -> Reads return 0x0A, 0x00, 0x0E; err = 0 throughout.
  -> wr_pulse_o = 0x01, 0x02, 0x04 on consecutive cycles.
  -> One response per cycle, each 1 cycle after its command.
- status_i word 0 = 0xDEADBEEF; read addr 0x20 (idx 8) -> rdata 0xDEADBEEF, err 0.
  Write 0x1 to 0x20 -> err 1 and status read unchanged.
- Read addr 0x30 (idx 12, out of range) -> rdata 0, err 1.
  Write there -> err 1, ctrl_regs_o unchanged, wr_pulse_o stays 0.
- Hold rsp_ready low 3 cycles with cmd_valid high on a pending read of reg 1.
  -> cmd_ready = 0 for those cycles and rsp_rdata stays stable.
  -> After release, exactly one response per command, in order.
- Assert rst_n low one cycle after a write fires, before the response is taken.
  -> rsp_valid = 0 immediately, all registers = CTRL_RST, no wr_pulse_o.
- With ICB_SLV_WMASK_EN: reg 0 = 0x11223344; write 0xAABBCCDD with mask 0b0101.
  -> Read returns 0x11BB33DD.
  -> Mask 0b0000: reg unchanged, no pulse, err 0.

Source files
------------

// File: rtl/icb_reg_slave.sv
// ICB register-bank slave: R/W control registers, read-only status words, error on out-of-range.
// Optional byte write mask on control writes when ICB_SLV_WMASK_EN is defined.
module icb_reg_slave #(
  parameter int              DW       = 32,
  parameter int              AW       = 12,
  parameter int              NUM_CTRL = 8,
  parameter int              NUM_STAT = 4,
  parameter logic [DW-1:0]   CTRL_RST = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_icb_cmd_valid,
  output logic                     i_icb_cmd_ready,
  input  logic [AW-1:0]            i_icb_cmd_addr,
  input  logic                     i_icb_cmd_read,
  input  logic [DW-1:0]            i_icb_cmd_wdata,
`ifdef ICB_SLV_WMASK_EN
  input  logic [DW/8-1:0]          i_icb_cmd_wmask,
`endif
  output logic                     i_icb_rsp_valid,
  input  logic                     i_icb_rsp_ready,
  output logic [DW-1:0]            i_icb_rsp_rdata,
  output logic                     i_icb_rsp_err,
  output logic [NUM_CTRL*DW-1:0]   ctrl_regs_o,
  input  logic [NUM_STAT*DW-1:0]   status_i,
  output logic [NUM_CTRL-1:0]      wr_pulse_o
);

  if (NUM_CTRL + NUM_STAT > (1 << (AW - 2))) begin : g_bad_cfg
    $error("icb_reg_slave: NUM_CTRL + NUM_STAT exceeds the addressable word range");
  end

  logic                rspValid_q;
  logic [DW-1:0]       rspRdata_q;
  logic                rspErr_q;
  logic [DW-1:0]       ctrl_q [NUM_CTRL];
  logic [NUM_CTRL-1:0] wrPulse_q;

  logic                cmdFire;
  logic                rspFire;
  logic [31:0]         cmdIdx;
  logic                isCtrl;
  logic                isStat;
  logic [DW-1:0]       rspRdata_d;
  logic                rspErr_d;
  logic [NUM_CTRL-1:0] wrHit;
  logic [NUM_CTRL-1:0] wrEn;
  logic [DW-1:0]       bitMask;
  logic                anyByte;
  logic                unused_addrLsb;

  assign unused_addrLsb  = ^i_icb_cmd_addr[1:0];

  // The single response slot frees up in the same cycle it is consumed.
  assign i_icb_cmd_ready = ~rspValid_q | i_icb_rsp_ready;
  assign cmdFire         = i_icb_cmd_valid & i_icb_cmd_ready;
  assign rspFire         = rspValid_q & i_icb_rsp_ready;

  assign cmdIdx = 32'(i_icb_cmd_addr[AW-1:2]);
  assign isCtrl = cmdIdx < 32'(NUM_CTRL);
  assign isStat = (cmdIdx >= 32'(NUM_CTRL)) && (cmdIdx < 32'(NUM_CTRL + NUM_STAT));

`ifdef ICB_SLV_WMASK_EN
  always_comb begin
    bitMask = '0;
    for (int b = 0; b < DW/8; b++) begin
      bitMask[b*8 +: 8] = {8{i_icb_cmd_wmask[b]}};
    end
    anyByte = |i_icb_cmd_wmask;
  end
`else
  assign bitMask = '1;
  assign anyByte = 1'b1;
`endif

  always_comb begin
    rspRdata_d = '0;
    rspErr_d   = 1'b0;
    wrHit      = '0;
    if (isCtrl) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (cmdIdx == 32'(k)) begin
          if (i_icb_cmd_read) begin
            rspRdata_d = ctrl_q[k];
          end else begin
            wrHit[k] = anyByte;
          end
        end
      end
    end else if (isStat) begin
      if (i_icb_cmd_read) begin
        for (int s = 0; s < NUM_STAT; s++) begin
          if (cmdIdx == 32'(NUM_CTRL + s)) begin
            rspRdata_d = status_i[s*DW +: DW];
          end
        end
      end else begin
        rspErr_d = 1'b1;
      end
    end else begin
      rspErr_d = 1'b1;
    end
  end

  assign wrEn = wrHit & {NUM_CTRL{cmdFire}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        ctrl_q[k] <= CTRL_RST;
      end
      wrPulse_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (wrEn[k]) begin
          ctrl_q[k] <= (ctrl_q[k] & ~bitMask) | (i_icb_cmd_wdata & bitMask);
        end
      end
      wrPulse_q <= wrEn;
    end
  end

  // A new command overwrites the slot even while the old response is leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end else if (cmdFire) begin
      rspValid_q <= 1'b1;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
    end else if (rspFire) begin
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
    end
  end

  always_comb begin
    ctrl_regs_o = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      ctrl_regs_o[k*DW +: DW] = ctrl_q[k];
    end
  end

  assign i_icb_rsp_valid = rspValid_q;
  assign i_icb_rsp_rdata = rspRdata_q;
  assign i_icb_rsp_err   = rspErr_q;
  assign wr_pulse_o      = wrPulse_q;

endmodule

// File: tb/tb_icb_reg_slave.sv
// Directed self-checking bench for icb_reg_slave (default parameters).
// Exercises the byte-mask path too when ICB_SLV_WMASK_EN is defined.
module tb_icb_reg_slave;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int NC = 8;
   localparam int NS = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmdValid;
   logic             cmdReady;
   logic [AW-1:0]    cmdAddr;
   logic             cmdRead;
   logic [DW-1:0]    cmdWdata;
`ifdef ICB_SLV_WMASK_EN
   logic [DW/8-1:0]  cmdWmask;
`endif
   logic             rspValid;
   logic             rspReady;
   logic [DW-1:0]    rspRdata;
   logic             rspErr;
   logic [NC*DW-1:0] ctrlRegs;
   logic [NS*DW-1:0] statusIn;
   logic [NC-1:0]    wrPulse;

   int compareCount = 0;
   int failCount = 0;
   int rspFires = 0;
   int rspFiresStart;

   icb_reg_slave dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_icb_cmd_valid (cmdValid),
      .i_icb_cmd_ready (cmdReady),
      .i_icb_cmd_addr  (cmdAddr),
      .i_icb_cmd_read  (cmdRead),
      .i_icb_cmd_wdata (cmdWdata),
`ifdef ICB_SLV_WMASK_EN
      .i_icb_cmd_wmask (cmdWmask),
`endif
      .i_icb_rsp_valid (rspValid),
      .i_icb_rsp_ready (rspReady),
      .i_icb_rsp_rdata (rspRdata),
      .i_icb_rsp_err   (rspErr),
      .ctrl_regs_o     (ctrlRegs),
      .status_i        (statusIn),
      .wr_pulse_o      (wrPulse)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Counts every response handshake so duplication or loss shows up
   always @(posedge clk) begin
      if (rst_n && rspValid && rspReady) rspFires++;
   end

   // One comparison point: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives the command channel fields
   task automatic applyStimulus(input logic valid, input logic read, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      cmdValid = valid;
      cmdRead  = read;
      cmdAddr  = addr;
      cmdWdata = wdata;
   endtask

   // Presents one command and checks its response one cycle later
   task automatic doTxn(input string tag, input logic read, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] expRdata, input logic expErr, input logic [NC-1:0] expPulse);
      applyStimulus(1'b1, read, addr, wdata);
      @(negedge clk);
      checkOutput({tag, " rsp_valid"}, rspValid, 1'b1);
      checkOutput({tag, " rdata"}, rspRdata, expRdata);
      checkOutput({tag, " err"}, rspErr, expErr);
      checkOutput({tag, " wr_pulse"}, wrPulse, expPulse);
   endtask

   // Drops cmd_valid and lets the last response drain
   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, '0, '0);
      @(negedge clk);
   endtask

   // Directed sequence; all expected values are hand-computed constants
   initial begin
      rspReady = 1'b1;
      statusIn = '0;
      applyStimulus(1'b0, 1'b0, '0, '0);
`ifdef ICB_SLV_WMASK_EN
      cmdWmask = '1;
`endif
      repeat (2) @(negedge clk);
      checkOutput("reset rsp_valid", rspValid, 1'b0);
      checkOutput("reset rdata", rspRdata, 32'h0);
      checkOutput("reset err", rspErr, 1'b0);
      checkOutput("reset wr_pulse", wrPulse, 8'h00);
      checkOutput("reset ctrl", ctrlRegs, 256'h0);
      rst_n = 1'b1;
      #1;
      checkOutput("ready after reset", cmdReady, 1'b1);

      doTxn("wr0", 1'b0, 12'h000, 32'h0000000A, 32'h0, 1'b0, 8'h01);
      doTxn("wr1", 1'b0, 12'h004, 32'h0000000C, 32'h0, 1'b0, 8'h02);
      doTxn("wr2", 1'b0, 12'h008, 32'h0000000E, 32'h0, 1'b0, 8'h04);
      doTxn("rd0", 1'b1, 12'h000, 32'h0, 32'h0000000A, 1'b0, 8'h00);
      doTxn("rd3", 1'b1, 12'h00C, 32'h0, 32'h00000000, 1'b0, 8'h00);
      doTxn("rd2", 1'b1, 12'h008, 32'h0, 32'h0000000E, 1'b0, 8'h00);
      doTxn("rd1 unaligned", 1'b1, 12'h006, 32'h0, 32'h0000000C, 1'b0, 8'h00);
      checkOutput("ctrl bus", ctrlRegs, {128'h0, 32'h0, 32'hE, 32'hC, 32'hA});
      idleCycle();
      checkOutput("drained rsp_valid", rspValid, 1'b0);

      statusIn[31:0]   = 32'hDEADBEEF;
      statusIn[127:96] = 32'h12345678;
      doTxn("stat0 rd", 1'b1, 12'h020, 32'h0, 32'hDEADBEEF, 1'b0, 8'h00);
      doTxn("stat0 wr", 1'b0, 12'h020, 32'h1, 32'h0, 1'b1, 8'h00);
      doTxn("stat0 reread", 1'b1, 12'h020, 32'h0, 32'hDEADBEEF, 1'b0, 8'h00);
      doTxn("stat3 rd", 1'b1, 12'h02C, 32'h0, 32'h12345678, 1'b0, 8'h00);
      doTxn("oor rd", 1'b1, 12'h030, 32'h0, 32'h0, 1'b1, 8'h00);
      doTxn("oor wr", 1'b0, 12'h030, 32'hFFFFFFFF, 32'h0, 1'b1, 8'h00);
      doTxn("top rd", 1'b1, 12'hFFC, 32'h0, 32'h0, 1'b1, 8'h00);
      checkOutput("ctrl after err wr", ctrlRegs, {128'h0, 32'h0, 32'hE, 32'hC, 32'hA});

      // Back-pressure: a pending read of reg 1 is held while reg 2 waits
      doTxn("bp rd1", 1'b1, 12'h004, 32'h0, 32'h0000000C, 1'b0, 8'h00);
      rspFiresStart = rspFires;
      rspReady = 1'b0;
      applyStimulus(1'b1, 1'b1, 12'h008, 32'h0);
      #1;
      checkOutput("bp ready low", cmdReady, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("bp hold ready", cmdReady, 1'b0);
         checkOutput("bp hold valid", rspValid, 1'b1);
         checkOutput("bp hold rdata", rspRdata, 32'h0000000C);
      end
      rspReady = 1'b1;
      #1;
      checkOutput("bp ready back", cmdReady, 1'b1);
      @(negedge clk);
      checkOutput("bp next valid", rspValid, 1'b1);
      checkOutput("bp next rdata", rspRdata, 32'h0000000E);
      idleCycle();
      checkOutput("bp drained", rspValid, 1'b0);
      checkOutput("bp response count", rspFires - rspFiresStart, 2);

      // Reset while a write response is still pending
      rspReady = 1'b0;
      applyStimulus(1'b1, 1'b0, 12'h004, 32'h00000055);
      @(negedge clk);
      checkOutput("pre-rst valid", rspValid, 1'b1);
      checkOutput("pre-rst pulse", wrPulse, 8'h02);
      checkOutput("pre-rst ctrl", ctrlRegs, {128'h0, 32'h0, 32'hE, 32'h55, 32'hA});
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0);
      #1;
      checkOutput("rst valid", rspValid, 1'b0);
      checkOutput("rst pulse", wrPulse, 8'h00);
      checkOutput("rst ctrl", ctrlRegs, 256'h0);
      @(negedge clk);
      checkOutput("rst held pulse", wrPulse, 8'h00);
      rst_n = 1'b1;
      rspReady = 1'b1;
      doTxn("post-rst rd1", 1'b1, 12'h004, 32'h0, 32'h0, 1'b0, 8'h00);
      idleCycle();

`ifdef ICB_SLV_WMASK_EN
      cmdWmask = 4'hF;
      doTxn("mask full wr", 1'b0, 12'h000, 32'h11223344, 32'h0, 1'b0, 8'h01);
      cmdWmask = 4'b0101;
      doTxn("mask 0101 wr", 1'b0, 12'h000, 32'hAABBCCDD, 32'h0, 1'b0, 8'h01);
      cmdWmask = 4'hF;
      doTxn("mask rd", 1'b1, 12'h000, 32'h0, 32'h11BB33DD, 1'b0, 8'h00);
      cmdWmask = 4'h0;
      doTxn("mask zero wr", 1'b0, 12'h000, 32'hFFFFFFFF, 32'h0, 1'b0, 8'h00);
      cmdWmask = 4'hF;
      doTxn("mask zero rd", 1'b1, 12'h000, 32'h0, 32'h11BB33DD, 1'b0, 8'h00);
      idleCycle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
